// File: rtl/fetch_hazard_if.sv
// Fetch hazard bus: pipeline-side inputs and fetch/pipeline-register controls.
// The pipeline side is the master and the hazard controller is the slave.
interface fetch_hazard_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 ex_branch;
    logic                 ex_alu_zero;
    logic                 id_ex_mem_read;
    logic [4:0]           id_ex_rd;
    logic [4:0]           if_id_rs1;
    logic [4:0]           if_id_rs2;
    logic                 halt_req;
    logic                 pc_write;
    logic                 if_id_write;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 halted;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        output ex_branch, ex_alu_zero, id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2, halt_req,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, halted, stall_count, flush_count
    );

    modport slave (
        input  ex_branch, ex_alu_zero, id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2, halt_req,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, halted, stall_count, flush_count
    );
endinterface

// File: rtl/fetch_hazard_controller.sv
// Fetch sequencing: boot hold, load-use stall, taken-branch flush and debug halt.
// Controls are combinational from state and inputs; perf counters are registered and saturating.
module fetch_hazard_controller #(
    parameter int BOOT_HOLD_CYCLES = 2,
    parameter int FLUSH_BUBBLES    = 2,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_hazard_if.slave        bus
);
    localparam int MAX_CNT = (BOOT_HOLD_CYCLES > FLUSH_BUBBLES) ? BOOT_HOLD_CYCLES : FLUSH_BUBBLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] BOOT_INIT  = CW'(BOOT_HOLD_CYCLES);
    localparam logic [CW-1:0] FLUSH_INIT = CW'((FLUSH_BUBBLES >= 2) ? FLUSH_BUBBLES - 2 : 0);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    logic taken;
    logic load_use;
    logic stall_evt;
    logic flush_evt;

    assign taken    = bus.ex_branch & bus.ex_alu_zero;
    assign load_use = bus.id_ex_mem_read & (bus.id_ex_rd != 5'd0) &
                      ((bus.id_ex_rd == bus.if_id_rs1) | (bus.id_ex_rd == bus.if_id_rs2));

    // Events only count in RUN; priority taken > halt_req > load_use makes them exclusive.
    assign flush_evt = (state == RUN) & taken;
    assign stall_evt = (state == RUN) & ~taken & ~bus.halt_req & load_use;

    always_comb begin
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.halted      = 1'b0;
        if (rst) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    bus.if_id_flush = 1'b1;
                    bus.id_ex_flush = 1'b1;
                end
                RUN: begin
                    if (taken) begin
                        bus.pc_write    = 1'b1;
                        bus.if_id_write = 1'b1;
                        bus.if_id_flush = 1'b1;
                        bus.id_ex_flush = 1'b1;
                    end else if (bus.halt_req) begin
                        bus.pc_write    = 1'b0;
                    end else if (load_use) begin
                        bus.id_ex_flush = 1'b1;
                    end else begin
                        bus.pc_write    = 1'b1;
                        bus.if_id_write = 1'b1;
                    end
                end
                FLUSH: begin
                    bus.pc_write    = 1'b1;
                    bus.if_id_write = 1'b1;
                    bus.if_id_flush = 1'b1;
                    bus.id_ex_flush = 1'b1;
                end
                HALT: begin
                    bus.halted      = 1'b1;
                end
                default: begin
                    bus.if_id_flush = 1'b1;
                    bus.id_ex_flush = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            cnt         <= BOOT_INIT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (cnt == '0) state <= RUN;
                    else           cnt   <= cnt - 1'b1;
                end
                RUN: begin
                    if (taken) begin
                        // A single-bubble flush is fully covered by the RUN cycle itself.
                        if (FLUSH_BUBBLES > 1) begin
                            state <= FLUSH;
                            cnt   <= FLUSH_INIT;
                        end
                    end else if (bus.halt_req) begin
                        state <= HALT;
                    end
                end
                FLUSH: begin
                    if (cnt == '0) state <= RUN;
                    else           cnt   <= cnt - 1'b1;
                end
                HALT: begin
                    if (!bus.halt_req) state <= RUN;
                end
                default: state <= BOOT;
            endcase

            if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Directed vector table against the default configuration, plus hand sequences
// on a BOOT_HOLD=0 / FLUSH_BUBBLES=1 / CNT_WIDTH=4 instance for boundary cases.
module tb_fetch_hazard_controller;
    logic clk = 1'b0;
    logic rst;
    logic ex_branch, ex_alu_zero, id_ex_mem_read, halt_req;
    logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_hazard_if #(.CNT_WIDTH(32)) bus0 ();
    fetch_hazard_if #(.CNT_WIDTH(4))  bus1 ();

    assign bus0.ex_branch      = ex_branch;
    assign bus0.ex_alu_zero    = ex_alu_zero;
    assign bus0.id_ex_mem_read = id_ex_mem_read;
    assign bus0.id_ex_rd       = id_ex_rd;
    assign bus0.if_id_rs1      = if_id_rs1;
    assign bus0.if_id_rs2      = if_id_rs2;
    assign bus0.halt_req       = halt_req;
    assign bus1.ex_branch      = ex_branch;
    assign bus1.ex_alu_zero    = ex_alu_zero;
    assign bus1.id_ex_mem_read = id_ex_mem_read;
    assign bus1.id_ex_rd       = id_ex_rd;
    assign bus1.if_id_rs1      = if_id_rs1;
    assign bus1.if_id_rs2      = if_id_rs2;
    assign bus1.halt_req       = halt_req;

    fetch_hazard_controller #(.BOOT_HOLD_CYCLES(2), .FLUSH_BUBBLES(2), .CNT_WIDTH(32)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    fetch_hazard_controller #(.BOOT_HOLD_CYCLES(0), .FLUSH_BUBBLES(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        logic       rst;
        logic       br;
        logic       z;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       halt;
        logic [4:0] ctl;  // {pc_write, if_id_write, if_id_flush, id_ex_flush, halted}
        int         sc;
        int         fc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic br, input logic z, input logic mr,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic h, input logic [4:0] ctl, input int sc, input int fc);
        vec_t v;
        v.rst = r; v.br = br; v.z = z; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.halt = h; v.ctl = ctl; v.sc = sc; v.fc = fc;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic br, input logic z, input logic mr,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic h);
        rst = r; ex_branch = br; ex_alu_zero = z; id_ex_mem_read = mr;
        id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2; halt_req = h;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    localparam logic [4:0] C_BOOT  = 5'b00110;
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_FLUSH = 5'b11110;
    localparam logic [4:0] C_HOLD  = 5'b00000;
    localparam logic [4:0] C_HALT  = 5'b00001;

    initial begin
        logic [4:0] ctl;
        //   rst br z mr rd  rs1 rs2 h  ctl      sc fc
        add(1, 0,0,0, 0, 0, 0, 0, C_BOOT,  0, 0);  // held in reset
        add(0, 0,0,0, 0, 0, 0, 0, C_BOOT,  0, 0);  // BOOT cnt=2
        add(0, 0,0,0, 0, 0, 0, 0, C_BOOT,  0, 0);  // BOOT cnt=1
        add(0, 0,0,0, 0, 0, 0, 0, C_BOOT,  0, 0);  // BOOT cnt=0
        add(0, 0,0,0, 0, 0, 0, 0, C_RUN,   0, 0);
        add(0, 0,0,1, 5, 0, 5, 0, C_STALL, 0, 0);  // load-use on rs2
        add(0, 0,0,0, 0, 0, 0, 0, C_RUN,   1, 0);
        add(0, 0,0,1, 0, 0, 0, 0, C_RUN,   1, 0);  // rd=0 never stalls
        add(0, 0,0,1, 3, 3, 7, 0, C_STALL, 1, 0);  // load-use on rs1
        add(0, 0,0,0, 0, 0, 0, 0, C_RUN,   2, 0);
        add(0, 1,1,0, 0, 0, 0, 0, C_FLUSH, 2, 0);  // taken branch
        add(0, 0,0,0, 0, 0, 0, 0, C_FLUSH, 2, 1);  // FLUSH cycle
        add(0, 0,0,0, 0, 0, 0, 0, C_RUN,   2, 1);
        add(0, 1,0,0, 0, 0, 0, 0, C_RUN,   2, 1);  // not taken
        add(0, 1,1,1, 5, 5, 0, 0, C_FLUSH, 2, 1);  // taken beats load-use
        add(0, 0,0,1, 5, 5, 0, 0, C_FLUSH, 2, 2);  // load-use ignored in FLUSH
        add(0, 0,0,0, 0, 0, 0, 0, C_RUN,   2, 2);
        add(0, 0,0,0, 0, 0, 0, 1, C_HOLD,  2, 2);  // halt_req 4 cycles
        add(0, 0,0,0, 0, 0, 0, 1, C_HALT,  2, 2);
        add(0, 0,0,0, 0, 0, 0, 1, C_HALT,  2, 2);
        add(0, 0,0,0, 0, 0, 0, 1, C_HALT,  2, 2);
        add(0, 0,0,0, 0, 0, 0, 0, C_HALT,  2, 2);  // exit cycle still HALT
        add(0, 0,0,0, 0, 0, 0, 0, C_RUN,   2, 2);
        add(0, 1,1,0, 0, 0, 0, 1, C_FLUSH, 2, 2);  // taken beats halt
        add(0, 0,0,0, 0, 0, 0, 1, C_FLUSH, 2, 3);
        add(0, 0,0,0, 0, 0, 0, 1, C_HOLD,  2, 3);  // halt honored after flush
        add(0, 0,0,0, 0, 0, 0, 0, C_HALT,  2, 3);
        add(0, 0,0,0, 0, 0, 0, 0, C_RUN,   2, 3);
        add(0, 1,1,0, 0, 0, 0, 0, C_FLUSH, 2, 3);
        add(1, 0,0,0, 0, 0, 0, 1, C_BOOT,  2, 4);  // rst mid-FLUSH
        add(0, 0,0,0, 0, 0, 0, 0, C_BOOT,  0, 0);
        add(0, 0,0,0, 0, 0, 0, 0, C_BOOT,  0, 0);
        add(0, 0,0,0, 0, 0, 0, 0, C_BOOT,  0, 0);
        add(0, 0,0,0, 0, 0, 0, 0, C_RUN,   0, 0);
        add(0, 0,0,1, 4, 4, 0, 1, C_HOLD,  0, 0);  // halt beats load-use
        add(0, 0,0,0, 0, 0, 0, 0, C_HALT,  0, 0);
        add(0, 0,0,0, 0, 0, 0, 0, C_RUN,   0, 0);

        drive(1, 0,0,0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].br, vecs[i].z, vecs[i].mr,
                  vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].halt);
            #1;
            ctl = {bus0.pc_write, bus0.if_id_write, bus0.if_id_flush, bus0.id_ex_flush, bus0.halted};
            chk($sformatf("vec%0d ctl", i), int'(ctl), int'(vecs[i].ctl));
            chk($sformatf("vec%0d stall_count", i), int'(bus0.stall_count), vecs[i].sc);
            chk($sformatf("vec%0d flush_count", i), int'(bus0.flush_count), vecs[i].fc);
        end

        // Second instance: single BOOT cycle, single-bubble flush, 4-bit saturation.
        @(negedge clk); drive(1, 0,0,0, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0,0,0, 0, 0, 0, 0); #1;
        chk("hold0 boot pc_write", int'(bus1.pc_write), 0);
        chk("hold0 boot if_id_flush", int'(bus1.if_id_flush), 1);
        @(negedge clk); #1;
        chk("hold0 run pc_write", int'(bus1.pc_write), 1);
        chk("hold0 run if_id_flush", int'(bus1.if_id_flush), 0);
        @(negedge clk); drive(0, 1,1,0, 0, 0, 0, 0); #1;
        chk("fb1 taken if_id_flush", int'(bus1.if_id_flush), 1);
        chk("fb1 taken flush_count", int'(bus1.flush_count), 0);
        @(negedge clk); drive(0, 0,0,0, 0, 0, 0, 0); #1;
        chk("fb1 after if_id_flush", int'(bus1.if_id_flush), 0);
        chk("fb1 after pc_write", int'(bus1.pc_write), 1);
        chk("fb1 flush_count", int'(bus1.flush_count), 1);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); drive(0, 0,0,1, 9, 9, 0, 0); #1;
            chk($sformatf("sat stall%0d pc_write", i), int'(bus1.pc_write), 0);
            chk($sformatf("sat stall%0d count", i), int'(bus1.stall_count), (i > 15) ? 15 : i);
        end
        @(negedge clk); drive(0, 0,0,0, 0, 0, 0, 0); #1;
        chk("sat final stall_count", int'(bus1.stall_count), 15);
        chk("sat final pc_write", int'(bus1.pc_write), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
